// File: rtl/countdown_timer.sv
// Loadable down-counter with load handshake, start/stop/pause control and
// optional auto-reload; emits a one-cycle done pulse at terminal count.
module countdown_timer #(
   parameter int unsigned Size = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load_valid,
   input  logic [Size-1:0] load_value,
   output logic            load_ready,
   input  logic            start,
   input  logic            stop,
   input  logic            pause,
   input  logic            autoreload,
   output logic [Size-1:0] count,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [Size-1:0] reload;
   logic [Size-1:0] reload_nxt;
   logic [Size-1:0] count_nxt;
   logic            done_nxt;
   logic            load_fire_c;

   // load_ready is kept equal to (state != RUN), so it qualifies the handshake
   assign load_fire_c = load_valid & load_ready;

   // State and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         reload     <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         reload     <= reload_nxt;
         done       <= done_nxt;
         busy       <= (state_nxt == RUN);
         load_ready <= (state_nxt != RUN);
      end
   end

   // Next-state and datapath decode
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (load_fire_c) begin
               count_nxt  = load_value;
               reload_nxt = load_value;
               state_nxt  = ARMED;
            end
         end
         ARMED: begin
            // a load in the same cycle as start wins and drops the start
            if (load_fire_c) begin
               count_nxt  = load_value;
               reload_nxt = load_value;
            end else if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (pause) begin
               state_nxt = RUN;
            end else if (count != '0) begin
               count_nxt = count - Size'(1);
            end else begin
               // terminal is detected at zero, so the decrement never wraps
               done_nxt = 1'b1;
               if (autoreload) begin
                  count_nxt = reload;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the timer.
module tb_countdown_timer;

   localparam int unsigned Size = 5;

   logic            clock;
   logic            reset;
   logic            load_valid;
   logic [Size-1:0] load_value;
   logic            load_ready;
   logic            start;
   logic            stop;
   logic            pause;
   logic            autoreload;
   logic [Size-1:0] count;
   logic            busy;
   logic            done;

   int errors;
   int checks;

   // Behavioural model: 0 = idle, 1 = armed, 2 = running
   int m_state;
   int m_count;
   int m_reload;
   int m_done;

   countdown_timer #(.Size(Size)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_value (load_value),
      .load_ready (load_ready),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .autoreload (autoreload),
      .count      (count),
      .busy       (busy),
      .done       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_count  = 0;
      m_reload = 0;
      m_done   = 0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      m_done = 0;
      if (m_state != 2 && load_valid) begin
         m_count  = int'(load_value);
         m_reload = int'(load_value);
         m_state  = 1;
      end else if (m_state == 1 && start) begin
         m_state = 2;
      end else if (m_state == 2) begin
         if (stop) begin
            m_state = 0;
         end else if (pause) begin
            m_state = 2;
         end else if (m_count > 0) begin
            m_count = m_count - 1;
         end else begin
            m_done = 1;
            if (autoreload) m_count = m_reload;
            else            m_state = 0;
         end
      end
   endtask

   task automatic check_model();
      check("count",      int'(count),      m_count);
      check("busy",       int'(busy),       (m_state == 2) ? 1 : 0);
      check("done",       int'(done),       m_done);
      check("load_ready", int'(load_ready), (m_state != 2) ? 1 : 0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      check_model();
   endtask

   task automatic drive(input logic lv, input int val, input logic st,
                        input logic sp, input logic ps, input logic ar);
      load_valid = lv;
      load_value = Size'(val);
      start      = st;
      stop       = sp;
      pause      = ps;
      autoreload = ar;
   endtask

   // Tick until done is seen or the budget runs out; n = edges taken
   task automatic edges_to_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done !== 1'b1 && n < 64);
   endtask

   int n;

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_model();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Load 4, start, no auto-reload: done five edges after start
      drive(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("start_count", int'(count), 4);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      edges_to_done(n);
      check("load4_latency", n, 5);
      check("load4_busy_fall", int'(busy), 0);

      // Auto-reload 2: done every 3 cycles, count back at 2 with done
      drive(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      edges_to_done(n);
      check("ar_first", n, 3);
      check("ar_count_at_done", int'(count), 2);
      edges_to_done(n);
      check("ar_period", n, 3);
      drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
      check("ar_stop_busy", int'(busy), 0);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick();

      // Load 3 with two pause cycles at count 2: done after 6 edges, not 4
      drive(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      check("pause_at2", int'(count), 2);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); tick();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      edges_to_done(n);
      check("pause_latency", n + 3, 6);

      // Stop coinciding with terminal count: stop wins, no done
      drive(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      check("stop_term_done", int'(done), 0);
      check("stop_term_ready", int'(load_ready), 1);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

      // Load 0 then start: done one edge later
      drive(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      edges_to_done(n);
      check("load0_latency", n, 1);

      // Re-load 7 over 5 while armed; loads during the run are ignored
      drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("reload_armed", int'(count), 7);
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("run_ready_low", int'(load_ready), 0);
      drive(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      edges_to_done(n);
      check("reload7_latency", n, 8);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

      // Asynchronous reset at count 3 with no clock edge
      drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick(); tick();
      check("pre_reset_count", int'(count), 3);
      #2;
      reset = 1'b0;
      #1;
      check("rst_count", int'(count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(load_ready), 1);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      check("idle_start_ignored", int'(busy), 0);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a load handshake, start/stop/pause control and optional auto-reload. It is the decrementing counterpart to the up-counting `counter` block. It sits beside `counter` in the design and uses the same `Size` parameter and the same `clock`/`reset` port names. It reports a one-cycle `done` pulse at terminal count and is driven by the Ruby-VPI runner through its ports.

## Interface
- Size, 5, width of `count`, `load_value` and the internal reload register
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset; asserting low clears all state immediately, release is sampled on posedge
- load_valid  in  1  load request qualifier
- load_value  in  Size  value to load into `count` and the reload register
- load_ready  out  1  high when a load is accepted: state IDLE or ARMED
- start  in  1  begin counting; honoured only in ARMED
- stop  in  1  abort counting; honoured only in RUN
- pause  in  1  hold `count` while in RUN
- autoreload  in  1  sampled at terminal count; 1 = reload and continue
- count  out  Size  current counter value (registered)
- busy  out  1  high while state is RUN (registered)
- done  out  1  one-cycle pulse after terminal count (registered)

## Operation
- States:
  - IDLE: no valid value loaded.
  - ARMED: a value is loaded and the block is waiting for `start`.
  - RUN: counting down.
- Reset values (reset low): state IDLE, `count`=0, reload=0, `done`=0, `busy`=0, `load_ready`=1.
- Load: a `load_valid`&`load_ready` handshake at a posedge sets `count` and reload to `load_value`. State goes to ARMED, from IDLE or from ARMED.
  - A re-load in ARMED overwrites the previous value.
  - `load_valid` in RUN is ignored; `load_ready` is 0 there.
- IDLE:
  - `start` is ignored.
  - `count` holds.
- ARMED:
  - `start`=1 → RUN.
  - Load and start in the same cycle: the load wins, state stays ARMED, `start` is dropped.
- RUN, evaluated in priority order each posedge:
  1. `stop`=1 → IDLE, `count` holds its current value, no `done`.
  2. `pause`=1 → no change.
  3. `count`≠0 → `count`←`count`−1.
  4. `count`=0 (terminal) → `done`←1 for exactly one cycle.
     - `autoreload`=1: `count`←reload, stay RUN.
     - `autoreload`=0: → IDLE, `count` stays 0.
- `done` clears on the next posedge unless a new terminal event occurs.
- Arithmetic: unsigned, width `Size`. The decrement never wraps, because terminal is detected at 0 before any decrement. Reload 0 with auto-reload gives `done` every cycle while in RUN.
- Reset mid-RUN: immediate return to reset values. A pending `done` is lost.

## Timing
- `start` sampled at edge E0 → after E0 state is RUN, `busy`=1, `count`=N.
- Edges E1..EN decrement `count` to 0. Edge EN+1 detects terminal, so `done`=1 during the cycle after EN+1.
- Without auto-reload: `busy`=0 from EN+1.
- Load N to `done`: N+1 RUN cycles after the start edge. Load 0 gives `done` after E1.
- Auto-reload period: N+1 cycles between `done` pulses. `count` equals N in the cycle that `done` is high.
- Each cycle with `pause` high extends the run by one cycle. `done` is never asserted while `pause` is high.
- `load_ready` is a decode of the state register; it falls in the cycle after the start edge.

## Test plan
- Reset low mid-count (`count`=3) → `count`=0, `busy`=0, `done`=0, `load_ready`=1 with no clock edge required; a `start` after release is ignored (IDLE).
- Load 4, start, `autoreload`=0 → `count` 4,3,2,1,0 then `done` for one cycle 5 edges after start; `busy` falls with it; state is IDLE.
- Load 2, `autoreload`=1 → `done` every 3 cycles; `count` sequence 2,1,0,2,1,0,…; `stop` asserted → IDLE with `count` held and no further `done`.
- Load 3, start, `pause` high for 2 cycles at `count`=2 → `done` delayed by exactly 2 cycles relative to the unpaused run.
- `stop` and terminal count in the same cycle → no `done`, state IDLE; load 0 then start → `done` one edge after start.
- Re-load 7 while ARMED with 5; `load_valid` during RUN → RUN run is unaffected, `load_ready`=0; ARMED re-load yields a 7-count run.
